// File: rtl/vscodec_spi_ctrl.sv
// Avalon-MM SPI master for a VS10xx-style codec: TX byte FIFO, DREQ-paced mode-0 shifter, codec reset control.
// Define VSCODEC_SPI_IRQ_EN to add the IRQ enable register at address 4 and a live irq output.
module vscodec_spi_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  codec_ctrl,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        vs_xcs,
  output logic        vs_xdcs,
  output logic        vs_xreset,
  input  logic        vs_dreq,
  output logic        irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [AW:0] DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DREQ = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW-1:0]   rptr_r;
  logic [AW:0]     count_r;
  logic [7:0]      div_cnt_r;
  logic [7:0]      shreg_r;
  logic [7:0]      rxsh_r;
  logic [7:0]      rx_r;
  logic [2:0]      bit_cnt_r;
  logic            sclk_r;
  logic            mosi_r;
  logic            xcs_r;
  logic            xdcs_r;
  logic            xreset_r;
  logic            ovf_r;
  logic            dreq_meta_r;
  logic            dreq_sync_r;

  logic            wr_s;
  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_set_s;
  logic            ovf_clr_s;
  logic            codec_rst_s;
  logic            enable_s;
  logic            empty_s;
  logic            full_s;
  logic            busy_s;
  logic            tick_s;
  logic            rise_s;
  logic            fall_s;
  logic            done_s;
  logic [3:0]      level_s;
  logic [7:0]      head_s;
  logic            unused_s;

  assign wr_s        = chipselect & ~write_n;
  assign push_req_s  = wr_s & (address == 3'd0);
  assign codec_rst_s = codec_ctrl[0];
  assign enable_s    = codec_ctrl[2];
  assign empty_s     = (count_r == '0);
  assign full_s      = (count_r == DEPTH_C);
  assign busy_s      = (state_r != ST_IDLE);
  assign tick_s      = (div_cnt_r == DIV_LAST);
  assign level_s     = 4'(count_r);
  assign head_s      = mem_r[rptr_r];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_s      = push_req_s & ~codec_rst_s & (~full_s | pop_s);
  assign ovf_set_s   = push_req_s & ~codec_rst_s & full_s & ~pop_s;
  assign ovf_clr_s   = wr_s & (address == 3'd3) & writedata[0];
  assign unused_s    = ^{read_n, writedata[31:8]};

  // Two-flop synchronizer for the asynchronous codec data request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dreq_meta_r <= 1'b0;
      dreq_sync_r <= 1'b0;
    end else begin
      dreq_meta_r <= vs_dreq;
      dreq_sync_r <= dreq_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle shifter strobes.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    done_s  = 1'b0;
    if (codec_rst_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && enable_s) begin
            state_s = ST_WAIT_DREQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_DREQ: begin
          if (!enable_s || empty_s) begin
            state_s = ST_IDLE;
          end else if (dreq_sync_r) begin
            state_s = ST_SHIFT;
            pop_s   = 1'b1;
          end else begin
            state_s = ST_WAIT_DREQ;
          end
        end
        ST_SHIFT: begin
          if (tick_s && !sclk_r) begin
            rise_s  = 1'b1;
            state_s = ST_SHIFT;
          end else if (tick_s) begin
            fall_s = 1'b1;
            if (bit_cnt_r == 3'd7) begin
              done_s  = 1'b1;
              state_s = ST_GAP;
            end else begin
              state_s = ST_SHIFT;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_GAP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // TX FIFO storage and pointers; the codec reset request flushes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (codec_rst_s) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= writedata[7:0];
        wptr_r        <= wptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // SCLK divider: runs inside SHIFT and GAP, restarts on every half-period and state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 8'd0;
    end else if ((state_s == state_r) && ((state_r == ST_SHIFT) || (state_r == ST_GAP)) && !tick_s) begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end else begin
      div_cnt_r <= 8'd0;
    end
  end

  // Mode-0 shifter: chip select and MSB set up at the pop, MISO in on rise, MOSI out on fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      xcs_r     <= 1'b1;
      xdcs_r    <= 1'b1;
      shreg_r   <= 8'h00;
      rxsh_r    <= 8'h00;
      rx_r      <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (codec_rst_s) begin
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      xcs_r     <= 1'b1;
      xdcs_r    <= 1'b1;
      bit_cnt_r <= 3'd0;
    end else if (pop_s) begin
      shreg_r   <= head_s;
      mosi_r    <= head_s[7];
      xcs_r     <= ~codec_ctrl[1];
      xdcs_r    <= codec_ctrl[1];
      sclk_r    <= 1'b0;
      bit_cnt_r <= 3'd0;
    end else if (rise_s) begin
      sclk_r <= 1'b1;
      rxsh_r <= {rxsh_r[6:0], spi_miso};
    end else if (fall_s) begin
      sclk_r    <= 1'b0;
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shreg_r   <= {shreg_r[6:0], 1'b0};
      if (done_s) begin
        xcs_r  <= 1'b1;
        xdcs_r <= 1'b1;
        rx_r   <= rxsh_r;
      end else begin
        mosi_r <= shreg_r[6];
      end
    end else begin
      sclk_r <= sclk_r;
    end
  end

  // Codec hardware reset follows the PIO request through one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xreset_r <= 1'b0;
    end else begin
      xreset_r <= ~codec_ctrl[0];
    end
  end

  assign spi_sclk  = sclk_r;
  assign spi_mosi  = mosi_r;
  assign vs_xcs    = xcs_r;
  assign vs_xdcs   = xdcs_r;
  assign vs_xreset = xreset_r;

`ifdef VSCODEC_SPI_IRQ_EN
  logic ier_r;
  logic irq_r;

  // IRQ enable register and registered "drained and idle" interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ier_r <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      if (wr_s && (address == 3'd4)) begin
        ier_r <= writedata[0];
      end else begin
        ier_r <= ier_r;
      end
      irq_r <= ier_r & empty_s & (state_r == ST_IDLE);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // Zero-wait, side-effect-free register read mux.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      3'd1:    readdata = {20'h0_0000, level_s, 3'b000, ovf_r, busy_s, full_s, empty_s, dreq_sync_r};
      3'd2:    readdata = {24'h00_0000, rx_r};
`ifdef VSCODEC_SPI_IRQ_EN
      3'd4:    readdata = {31'h0000_0000, ier_r};
`endif
      default: readdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: doc/vscodec_spi_ctrl.md
VSCODEC_SPI_CTRL -- requirements
Module: vscodec_spi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO depth in bytes, power of two.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-006 SHALL have ports chipselect, write_n and read_n, each input, 1 bit: Avalon-MM strobes, write_n and read_n active-low.
REQ-007 SHALL have port writedata, input, 32 bits, and port readdata, output, 32 bits: Avalon-MM data.
REQ-008 SHALL have port codec_ctrl, input, 3 bits, driven by the codec PIO: bit0 codec reset request, bit1 select (1 = SCI via xcs, 0 = SDI via xdcs), bit2 engine enable.
REQ-009 SHALL have ports spi_sclk and spi_mosi, each output, 1 bit, and port spi_miso, input, 1 bit: SPI mode 0 bus.
REQ-010 SHALL have ports vs_xcs, vs_xdcs and vs_xreset, each output, 1 bit, active-low, and port vs_dreq, input, 1 bit, asynchronous: codec data request.
REQ-011 SHALL have port irq, output, 1 bit.

Function
REQ-012 SHALL push writedata[7:0] into the TX FIFO on a write to address 0; when the FIFO is full it SHALL drop the byte and set the sticky overflow flag.
REQ-013 SHALL return on a read of address 1: bit0 synced dreq, bit1 fifo_empty, bit2 fifo_full, bit3 busy, bit4 overflow, bits[11:8] fill level, all other bits 0.
REQ-014 SHALL return the last received MISO byte in readdata[7:0] on a read of address 2.
REQ-015 SHALL clear overflow on a write to address 3 with writedata[0]=1.
REQ-016 SHALL drive readdata combinationally (zero wait) and return 0 for unmapped addresses; reads SHALL have no side effects.
REQ-017 SHALL pass vs_dreq through a 2-flop synchronizer before use.
REQ-018 SHALL implement the FSM: IDLE -> WAIT_DREQ when the FIFO is non-empty, enable=1 and reset request=0; WAIT_DREQ -> SHIFT when synced dreq=1, popping one byte; SHIFT -> GAP after 8 bits; GAP -> IDLE after CLK_DIV cycles.
REQ-019 SHALL in SHIFT assert the selected chip select low (per codec_ctrl[1], sampled at the pop) one CLK_DIV period before the first rising SCLK edge.
REQ-020 SHALL shift MSB first: MOSI changes on the falling edge, MISO is sampled on the rising edge, and SCLK idles low.
REQ-021 SHALL hold both chip selects high in IDLE, WAIT_DREQ and GAP; a byte is never split across a chip-select deassertion.
REQ-022 SHALL let a FIFO push and a pop in the same cycle both succeed, leaving the level unchanged, including when the FIFO is full.
REQ-023 SHALL, while codec_ctrl[0]=1, drive vs_xreset low, flush the FIFO, abort any byte in flight, and force the FSM to IDLE with the chip selects high.
REQ-024 SHALL let enable=0 finish the current byte and then hold the FSM in IDLE.
REQ-025 SHALL assert busy in any state other than IDLE.

Reset
REQ-026 SHALL on reset set FSM=IDLE, FIFO empty, overflow=0, rx byte=0x00, spi_sclk=0, spi_mosi=0, vs_xcs=1, vs_xdcs=1, vs_xreset=0, irq=0, and dreq synchronizer=0.
REQ-027 SHALL drive vs_xreset from ~codec_ctrl[0] after reset release, with no extra latency beyond one register.

Configuration
REQ-028 SHALL, with VSCODEC_SPI_IRQ_EN defined, make address 4 an IRQ enable register (bit0 readable and writable); irq SHALL be asserted, registered, while IER[0]=1, the FIFO is empty and the FSM is in IDLE.
REQ-029 SHALL, with VSCODEC_SPI_IRQ_EN undefined, tie irq to 0 and make address 4 read 0 and ignore writes.

Verification
REQ-030 SHALL cover: codec_ctrl=3'b110 and write 0xA5 to addr0, dreq=1 -> vs_xcs low for one byte, MOSI bits 1,0,1,0,0,1,0,1, then status reads busy=0, empty=1.
REQ-031 SHALL cover: codec_ctrl=3'b100 and 9 writes with FIFO_DEPTH=8, dreq=0 -> level 8, full=1, overflow=1, vs_xdcs high throughout; writing 1 to addr3 clears overflow.
REQ-032 SHALL cover: 3 bytes queued, dreq dropped low mid-byte 1 -> byte 1 completes, byte 2 waits in WAIT_DREQ with the chip selects high until dreq returns.
REQ-033 SHALL cover: codec_ctrl[0] raised mid-SHIFT -> vs_xreset low next cycle, chip selects high, FIFO level 0, FSM IDLE.
REQ-034 SHALL cover: MISO driving 0x3C during a transfer -> addr2 reads 0x0000003C.
REQ-035 SHALL cover, with VSCODEC_SPI_IRQ_EN defined: IER=1, one byte sent -> irq rises after GAP completes and falls on the next write to addr0.
